writebuf_fsm_dropper: RTL and testbench
=======================================

// Module: writebuf_fsm_dropper
// PURPOSE
//  Write-side FSM of the EtherBlade line buffer. AXI-Stream slave that takes frames
//  byte-by-byte and writes each frame into one buffer line (BRAM write port). It tells
//  the CountersBlock when to advance the write char pointer, commit a line or rewind one.
//  Oversize and runt frames are dropped whole. The buffer read side never sees them.
// PARAMETERS
//  DATA_W   8     tdata / wr_data width
//  LEN_W    11    width of per-line char counter and wr_len
//  MAX_LEN  1518  max chars per line; the beat that would be char MAX_LEN+1 causes a drop
//  MIN_LEN  60    min committed frame length; shorter frames are dropped at tlast
//  STAT_W   16    width of the saturating statistics counters
// PORTS
//  clk           in   1       clock
//  rst           in   1       reset, synchronous, active-high
//  redflag       in   1       from CountersBlock: no free line (buffer full)
//  tvalid        in   1       AXI-in
//  tlast         in   1       AXI-in
//  tdata         in   DATA_W  AXI-in
//  tready        out  1       AXI-out
//  wr_en         out  1       BRAM write strobe
//  wr_data       out  DATA_W  BRAM write data (= tdata)
//  wr_char_incr  out  1       to CountersBlock: advance write char pointer
//  wr_newline    out  1       to CountersBlock: commit current line (1-cycle pulse)
//  wr_rewind     out  1       to CountersBlock: reset char pointer to line start (pulse)
//  wr_len        out  LEN_W   committed length, valid while wr_newline=1
//  frame_cnt     out  STAT_W  committed frames, saturating
//  drop_cnt      out  STAT_W  dropped frames, saturating
// BEHAVIOUR
//  beat = tvalid & tready; cnt = chars written in current line (LEN_W bits, internal)
//  Reset: state=IDLE, cnt=0; outputs all 0 except tready=~redflag (comb. in IDLE).
//  tready is combinational from state and redflag only, never from tvalid.
//  IDLE:   tready=~redflag. If redflag=1, stall (backpressure, no drop).
//          If beat: write it (cnt=1). If tlast, go COMMIT (1-byte frame, runt if
//          MIN_LEN>1). Otherwise go WRITE.
//  WRITE:  tready=1. If beat and cnt<MAX_LEN: write, cnt+1. If also tlast, go COMMIT.
//          If beat and cnt==MAX_LEN: no write, set drop flag. If tlast, go COMMIT.
//          Otherwise go DROP.
//  DROP:   tready=1. Discard beats (wr_en=0). On beat with tlast, go COMMIT.
//  COMMIT: tready=0, exactly 1 bubble cycle so the CountersBlock can update redflag.
//          If not dropped and cnt>=MIN_LEN: wr_newline=1, wr_len=cnt, frame_cnt+1.
//          Otherwise: wr_rewind=1, drop_cnt+1.
//          Then cnt=0, drop flag=0, go IDLE.
//  wr_en, wr_char_incr, wr_data are combinational, asserted in the same cycle as the
//    accepted beat that is written. wr_char_incr==wr_en always.
//  wr_newline and wr_rewind are mutually exclusive. Both are 0 outside COMMIT.
//    wr_len=0 when wr_newline=0.
//  Latency: last beat accepted at cycle N -> commit/rewind pulse at N+1; next beat
//    can be accepted at N+2 at the earliest.
//  tvalid=0 mid-frame: hold state, no pulses. Counters hold when no beat.
//  redflag rising mid-frame: ignored. The line is already owned; the drop
//    decision depends only on length.
//  Stat counters saturate at all-ones and do not wrap.
//  rst mid-frame: return to IDLE, cnt=0. No commit/rewind pulse is issued; the
//    CountersBlock is reset by the same rst. Stats are cleared.
// STRUCTURE
//  Shared package eblade_buf_pkg: state encoding (IDLE/WRITE/DROP/COMMIT, 2 bits),
//    MAX_LEN/MIN_LEN defaults, LEN_W.
//  Sub-module sat_counter (STAT_W, inc, rst): instantiated twice, for frame_cnt
//    and drop_cnt.
//  Everything else (FSM, cnt, drop flag, pulse regs) lives in this module.
// TESTING
//  64-byte frame, tvalid always 1, redflag=0 -> 64 wr_en pulses; next cycle
//    wr_newline=1, wr_len=64, tready=0; frame_cnt=1.
//  Same 64-byte frame with tvalid gaps of 3 cycles every 8 beats -> still exactly
//    64 wr_en pulses, wr_len=64, no pulse during the gaps.
//  1600-byte frame -> 1518 writes, then 82 discarded beats with tready=1;
//    then wr_rewind=1, drop_cnt=1, no wr_newline.
//  40-byte frame (runt) -> 40 writes, then wr_rewind=1, drop_cnt=1.
//  Frames of exactly MAX_LEN and exactly MIN_LEN -> both committed with the exact
//    length on wr_len.
//  redflag=1 in IDLE with tvalid=1 -> tready=0 and no writes. Drop redflag
//    -> first beat accepted in the same cycle.
//  rst asserted at beat 10 of a frame -> next cycle: IDLE, all outputs 0, no pulse.
//    A new 64-byte frame then commits with wr_len=64.

Source files
------------

// File: rtl/eblade_buf_pkg.sv
// Shared definitions for the EtherBlade line buffer: write FSM state encoding,
// default line-length limits and a small length-qualification helper.
package eblade_buf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WRITE  = 2'd1,
    ST_DROP   = 2'd2,
    ST_COMMIT = 2'd3
  } wb_state_e;

  localparam int LEN_W_DEF   = 11;
  localparam int MAX_LEN_DEF = 1518;
  localparam int MIN_LEN_DEF = 60;

  function automatic logic len_ok(input int len, input int min_len);
    return len >= min_len;
  endfunction

endpackage

// File: rtl/writebuf_fsm_dropper_if.sv
// AXI-Stream byte channel feeding the line-buffer write side.
interface writebuf_fsm_dropper_if #(
  parameter int DATA_W = 8
);
  logic              tvalid;
  logic              tlast;
  logic [DATA_W-1:0] tdata;
  logic              tready;

  modport master(output tvalid, output tlast, output tdata, input tready);
  modport slave(input tvalid, input tlast, input tdata, output tready);
endinterface

// File: rtl/sat_counter.sv
// Statistics counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/writebuf_fsm_dropper.sv
// Write-side FSM of the EtherBlade line buffer: writes one frame per line, then
// commits it or rewinds it (oversize / runt frames are dropped whole).
module writebuf_fsm_dropper
  import eblade_buf_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int LEN_W   = LEN_W_DEF,
  parameter int MAX_LEN = MAX_LEN_DEF,
  parameter int MIN_LEN = MIN_LEN_DEF,
  parameter int STAT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    redflag,
  writebuf_fsm_dropper_if.slave   axis,
  output logic                    wr_en,
  output logic [DATA_W-1:0]       wr_data,
  output logic                    wr_char_incr,
  output logic                    wr_newline,
  output logic                    wr_rewind,
  output logic [LEN_W-1:0]        wr_len,
  output logic [STAT_W-1:0]       frame_cnt,
  output logic [STAT_W-1:0]       drop_cnt
);

  wb_state_e        state;
  logic [LEN_W-1:0] cnt;
  logic [LEN_W-1:0] cnt_inc;
  logic             dropped;
  logic             beat;
  logic             room;
  logic             write_ok;
  logic             newline_q;
  logic             rewind_q;
  logic [LEN_W-1:0] len_q;

  // tready depends on state and redflag only, so upstream never sees a tvalid loop
  always_comb begin
    axis.tready = 1'b0;
    unique case (state)
      ST_IDLE:   axis.tready = ~redflag;
      ST_WRITE:  axis.tready = 1'b1;
      ST_DROP:   axis.tready = 1'b1;
      ST_COMMIT: axis.tready = 1'b0;
      default:   axis.tready = 1'b0;
    endcase
  end

  assign beat     = axis.tvalid & axis.tready;
  assign cnt_inc  = cnt + LEN_W'(1);
  assign room     = cnt < LEN_W'(MAX_LEN);
  assign write_ok = beat && ((state == ST_IDLE) || ((state == ST_WRITE) && room));

  assign wr_en        = write_ok;
  assign wr_char_incr = write_ok;
  assign wr_data      = write_ok ? axis.tdata : '0;
  assign wr_newline   = newline_q;
  assign wr_rewind    = rewind_q;
  assign wr_len       = len_q;

  // Commit/rewind is decided on the transition into COMMIT so the pulses come out of flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      dropped   <= 1'b0;
      newline_q <= 1'b0;
      rewind_q  <= 1'b0;
      len_q     <= '0;
    end else begin
      newline_q <= 1'b0;
      rewind_q  <= 1'b0;
      len_q     <= '0;
      unique case (state)
        ST_IDLE: begin
          if (beat) begin
            cnt <= LEN_W'(1);
            if (axis.tlast) begin
              state     <= ST_COMMIT;
              newline_q <= len_ok(1, MIN_LEN);
              rewind_q  <= !len_ok(1, MIN_LEN);
              len_q     <= len_ok(1, MIN_LEN) ? LEN_W'(1) : '0;
            end else begin
              state <= ST_WRITE;
            end
          end
        end
        ST_WRITE: begin
          if (beat) begin
            if (room) begin
              cnt <= cnt_inc;
              if (axis.tlast) begin
                state     <= ST_COMMIT;
                newline_q <= !dropped && len_ok(int'(cnt_inc), MIN_LEN);
                rewind_q  <= dropped || !len_ok(int'(cnt_inc), MIN_LEN);
                len_q     <= (!dropped && len_ok(int'(cnt_inc), MIN_LEN)) ? cnt_inc : '0;
              end
            end else begin
              dropped <= 1'b1;
              if (axis.tlast) begin
                state    <= ST_COMMIT;
                rewind_q <= 1'b1;
              end else begin
                state <= ST_DROP;
              end
            end
          end
        end
        ST_DROP: begin
          if (beat && axis.tlast) begin
            state    <= ST_COMMIT;
            rewind_q <= 1'b1;
          end
        end
        ST_COMMIT: begin
          cnt     <= '0;
          dropped <= 1'b0;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  sat_counter #(.W(STAT_W)) u_frame_cnt (
    .clk (clk),
    .rst (rst),
    .inc (newline_q),
    .cnt (frame_cnt)
  );

  sat_counter #(.W(STAT_W)) u_drop_cnt (
    .clk (clk),
    .rst (rst),
    .inc (rewind_q),
    .cnt (drop_cnt)
  );

endmodule

// File: tb/tb_writebuf_fsm_dropper.sv
// Scoreboard bench for writebuf_fsm_dropper: frame-level reference model predicts
// written bytes, commit/rewind events and statistics; a negedge monitor checks them.
module tb_writebuf_fsm_dropper;

  localparam int MAX_LEN = 1518;
  localparam int MIN_LEN = 60;
  localparam int STAT_MAX = 65535;

  typedef struct {
    logic is_commit;
    int   len;
    int   cyc;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redflag = 1'b0;
  logic        wr_en, wr_char_incr, wr_newline, wr_rewind;
  logic [7:0]  wr_data;
  logic [10:0] wr_len;
  logic [15:0] frame_cnt, drop_cnt;

  writebuf_fsm_dropper_if #(.DATA_W(8)) axis ();

  writebuf_fsm_dropper dut (
    .clk          (clk),
    .rst          (rst),
    .redflag      (redflag),
    .axis         (axis),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .wr_char_incr (wr_char_incr),
    .wr_newline   (wr_newline),
    .wr_rewind    (wr_rewind),
    .wr_len       (wr_len),
    .frame_cnt    (frame_cnt),
    .drop_cnt     (drop_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  logic [7:0] byte_q[$];
  ev_t        ev_q[$];
  int exp_frames = 0;
  int exp_drops  = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT writes a byte or pulses a commit/rewind.
  always @(negedge clk) begin
    if (!rst) begin
      if (wr_en || wr_char_incr) begin
        chk("wr_char_incr_eq_wr_en", int'(wr_char_incr), int'(wr_en));
        if (byte_q.size() == 0) chk("unexpected_write", 1, 0);
        else chk("wr_data", int'(wr_data), int'(byte_q.pop_front()));
      end
      if (wr_newline || wr_rewind) begin
        ev_t e;
        chk("pulse_exclusive", int'(wr_newline & wr_rewind), 0);
        chk("commit_tready", int'(axis.tready), 0);
        if (ev_q.size() == 0) begin
          chk("unexpected_pulse", 1, 0);
        end else begin
          e = ev_q.pop_front();
          chk("pulse_kind_newline", int'(wr_newline), int'(e.is_commit));
          chk("wr_len", int'(wr_len), e.is_commit ? e.len : 0);
          chk("pulse_cycle", cyc, e.cyc);
        end
      end else if (wr_len != '0) begin
        chk("wr_len_without_newline", int'(wr_len), 0);
      end
    end
  end

  task automatic drive_beat(input logic [7:0] d, input logic last,
                            output int stalls, output int acc_cyc);
    int budget;
    budget  = 400;
    stalls  = 0;
    acc_cyc = 0;
    axis.tvalid = 1'b1;
    axis.tdata  = d;
    axis.tlast  = last;
    forever begin
      @(negedge clk);
      if (axis.tready) begin
        acc_cyc = cyc;
        break;
      end
      stalls++;
      budget--;
      if (budget == 0) begin
        chk("accept_timeout", 1, 0);
        break;
      end
    end
    @(posedge clk);
    #1;
    axis.tvalid = 1'b0;
    axis.tlast  = 1'b0;
  endtask

  task automatic check_stats();
    chk("frame_cnt", int'(frame_cnt), exp_frames);
    chk("drop_cnt", int'(drop_cnt), exp_drops);
    chk("leftover_writes", byte_q.size(), 0);
    chk("leftover_pulses", ev_q.size(), 0);
  endtask

  // gap_mode: 0 none, 1 three idle cycles every 8 beats, 2 random idles + random redflag
  task automatic send_frame(input int len, input int gap_mode, input bit bubble,
                            output int stalls_total);
    logic [7:0] b;
    int st, acc;
    bit committed;
    ev_t e;
    stalls_total = 0;
    acc = 0;
    committed = (len >= MIN_LEN) && (len <= MAX_LEN);
    for (int i = 0; i < len; i++) begin
      b = 8'($urandom);
      if (i < MAX_LEN) byte_q.push_back(b);
      drive_beat(b, (i == len - 1), st, acc);
      stalls_total += st;
      if (gap_mode == 2) redflag = ($urandom_range(0, 3) == 0);
      if (i != len - 1) begin
        if (gap_mode == 1 && (i % 8) == 7) repeat (3) @(posedge clk);
        if (gap_mode == 2 && $urandom_range(0, 5) == 0)
          repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    redflag = 1'b0;
    e.is_commit = committed;
    e.len = len;
    e.cyc = acc + 1;
    ev_q.push_back(e);
    if (committed) exp_frames = (exp_frames == STAT_MAX) ? exp_frames : exp_frames + 1;
    else           exp_drops  = (exp_drops  == STAT_MAX) ? exp_drops  : exp_drops + 1;
    if (bubble) begin
      @(posedge clk);
      #1;
      check_stats();
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_tready"}, int'(axis.tready), 1);
    chk({tag, "_wr_en"}, int'(wr_en), 0);
    chk({tag, "_wr_newline"}, int'(wr_newline), 0);
    chk({tag, "_wr_rewind"}, int'(wr_rewind), 0);
    chk({tag, "_wr_len"}, int'(wr_len), 0);
    chk({tag, "_frame_cnt"}, int'(frame_cnt), 0);
    chk({tag, "_drop_cnt"}, int'(drop_cnt), 0);
  endtask

  initial begin
    #2ms;
    $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int st, acc;
    int lens[6];
    axis.tvalid = 1'b0;
    axis.tlast  = 1'b0;
    axis.tdata  = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_idle_outputs("reset");

    send_frame(64, 0, 1'b1, st);
    chk("plain64_stalls", st, 0);
    send_frame(64, 1, 1'b1, st);
    chk("gapped64_stalls", st, 0);
    send_frame(1600, 0, 1'b1, st);
    chk("oversize_stalls", st, 0);
    send_frame(40, 0, 1'b1, st);

    lens = '{MAX_LEN, MIN_LEN, MIN_LEN - 1, MAX_LEN + 1, 1, 2};
    foreach (lens[k]) begin
      send_frame(lens[k], 0, 1'b1, st);
      chk("boundary_stalls", st, 0);
    end

    // Full buffer in IDLE: stall without accepting, then accept as soon as redflag drops.
    redflag = 1'b1;
    axis.tvalid = 1'b1;
    axis.tdata  = 8'hA5;
    axis.tlast  = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("redflag_tready", int'(axis.tready), 0);
      chk("redflag_wr_en", int'(wr_en), 0);
    end
    @(posedge clk);
    #1;
    redflag = 1'b0;
    send_frame(64, 0, 1'b1, st);
    chk("redflag_release_stalls", st, 0);

    // Back-to-back: the commit bubble costs exactly one cycle before the next beat.
    send_frame(61, 0, 1'b0, st);
    send_frame(62, 0, 1'b1, st);
    chk("back_to_back_stalls", st, 1);

    // Synchronous reset in the middle of a frame.
    for (int i = 0; i < 10; i++) begin
      logic [7:0] b;
      b = 8'($urandom);
      byte_q.push_back(b);
      drive_beat(b, 1'b0, st, acc);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_frames = 0;
    exp_drops  = 0;
    check_idle_outputs("midrst");
    chk("midrst_leftover_writes", byte_q.size(), 0);
    send_frame(64, 0, 1'b1, st);
    chk("post_reset_stalls", st, 0);

    for (int n = 0; n < 40; n++) begin
      int r, len;
      r = $urandom_range(0, 9);
      if (r < 4)      len = $urandom_range(1, 12);
      else if (r < 8) len = $urandom_range(50, 80);
      else            len = $urandom_range(1510, 1530);
      send_frame(len, 2, 1'b1, st);
      chk("random_stalls", st, 0);
    end

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
